instr_mem: RTL and testbench
============================

INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, address width.
REQ-002 SHALL provide parameter DATA_W, default 5, instruction word width.
REQ-003 SHALL provide parameter DEPTH, default 16 (2**ADDR_W), number of words.
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on rising edge except reset.
REQ-005 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port read_addr  input  ADDR_W  word address to read.
REQ-007 SHALL provide port read_data  output  DATA_W  registered instruction word.
REQ-008 SHALL provide port wr_en  input  1  write strobe, active-high.
REQ-009 SHALL provide port wr_addr  input  ADDR_W  word address to write.
REQ-010 SHALL provide port wr_data  input  DATA_W  word to write.
REQ-011 Integrators not loading the memory SHALL tie wr_en to 0; wr_addr/wr_data are then don't-care.

Function
REQ-012 SHALL hold DEPTH words of DATA_W bits, addressed 0..DEPTH-1; every ADDR_W-bit address is valid, no wrap logic needed.
REQ-013 SHALL hold this default program (hex), loaded at reset: 0:01 1:02 2:04 3:08 4:10 5:03 6:05 7:06 8:09 9:0A 10:0C 11:11 12:12 13:14 14:18 15:1F.
REQ-014 Read SHALL be synchronous: on each rising clk, read_data <= mem[read_addr] sampled at that edge; latency exactly 1 cycle; no read enable.
REQ-015 read_data SHALL hold its value between rising edges regardless of read_addr changes.
REQ-016 Write SHALL be synchronous: on rising clk with wr_en=1, mem[wr_addr] <= wr_data.
REQ-017 Simultaneous read and write of the same address SHALL be read-first: read_data gets the old word; the new word is visible on the next read.
REQ-018 Writes to different addresses than read_addr in the same cycle SHALL not affect read_data.
REQ-019 wr_en=0 SHALL leave memory contents unchanged.
REQ-020 Written contents SHALL persist until overwritten or reset.

Reset
REQ-021 While rst=1, read_data SHALL be 0 immediately (asynchronous) and remain 0.
REQ-022 While rst=1, all words SHALL be restored to the default program of REQ-013 and writes SHALL be ignored.
REQ-023 Reset asserted mid-operation SHALL discard all prior writes.
REQ-024 On the first rising edge after rst deasserts, normal read/write per REQ-014..REQ-020 SHALL resume.

Verification
REQ-025 Reset then read_addr=0,1,2,3,4,5 on consecutive edges -> read_data 01,02,04,08,10,03, each one cycle after its address is sampled.
REQ-026 read_addr changed between edges (e.g. 0 -> 7 mid-cycle) -> read_data unchanged until next rising edge, then 06.
REQ-027 wr_en=1, wr_addr=5, wr_data=1E, read_addr=5 same edge -> read_data=03; next edge with read_addr=5 -> 1E.
REQ-028 Write 00 to address 15, read address 15 -> 00; assert rst -> read_data=0 immediately; after release read address 15 -> 1F.
REQ-029 wr_en=0 with wr_addr=2, wr_data=1B for several cycles -> address 2 still reads 04.
REQ-030 rst asserted between clock edges -> read_data goes 0 without waiting for clk.

Source files
------------

// File: rtl/instr_mem.sv
// Instruction memory: DEPTH x DATA_W words with a built-in default program restored on reset.
// Registered read (1-cycle latency, read-first on collisions) and synchronous write port.
module instr_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 5,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] read_data_q;

  // Boot program image; words beyond the first sixteen default to zero.
  function automatic logic [DATA_W-1:0] default_word(input int unsigned idx);
    logic [DATA_W-1:0] w;
    case (idx)
      0:       w = DATA_W'(8'h01);
      1:       w = DATA_W'(8'h02);
      2:       w = DATA_W'(8'h04);
      3:       w = DATA_W'(8'h08);
      4:       w = DATA_W'(8'h10);
      5:       w = DATA_W'(8'h03);
      6:       w = DATA_W'(8'h05);
      7:       w = DATA_W'(8'h06);
      8:       w = DATA_W'(8'h09);
      9:       w = DATA_W'(8'h0A);
      10:      w = DATA_W'(8'h0C);
      11:      w = DATA_W'(8'h11);
      12:      w = DATA_W'(8'h12);
      13:      w = DATA_W'(8'h14);
      14:      w = DATA_W'(8'h18);
      15:      w = DATA_W'(8'h1F);
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read samples mem_q (pre-write contents), giving read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= default_word(i);
      end
      read_data_q <= '0;
    end else begin
      mem_q       <= mem_d;
      read_data_q <= mem_q[read_addr];
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_instr_mem.sv
// Directed self-checking bench for instr_mem: default program, read latency/hold,
// read-first collisions, write enable gating and asynchronous reset restore.
module tb_instr_mem;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] read_addr = '0;
  logic [DATA_W-1:0] read_data;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] exp_prog [16] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h03, 5'h05, 5'h06,
                                       5'h09, 5'h0A, 5'h0C, 5'h11, 5'h12, 5'h14, 5'h18, 5'h1F};

  instr_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_addr (read_addr),
    .read_data (read_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Async reset with no clock edge yet
    #1 rst = 1'b1;
    #1 check("reset_async_initial", read_data, 5'h00);
    @(negedge clk);
    check("reset_held", read_data, 5'h00);
    rst = 1'b0;

    // Full default program, one cycle after each address is sampled
    for (int i = 0; i < 16; i++) begin
      read_addr = ADDR_W'(i);
      step();
      check($sformatf("default_prog_%0d", i), read_data, exp_prog[i]);
    end

    // Hold between edges despite read_addr change
    read_addr = 4'd0;
    step();
    check("hold_before", read_data, 5'h01);
    #2 read_addr = 4'd7;
    #1 check("hold_midcycle", read_data, 5'h01);
    step();
    check("hold_after_edge", read_data, 5'h06);

    // Read-first collision
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 5'h1E; read_addr = 4'd5;
    step();
    check("collision_old_word", read_data, 5'h03);
    wr_en = 1'b0;
    step();
    check("collision_new_word", read_data, 5'h1E);

    // Write to a different address does not disturb read
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 5'h15; read_addr = 4'd7;
    step();
    check("diff_addr_read", read_data, 5'h06);
    wr_en = 1'b0; read_addr = 4'd6;
    step();
    check("diff_addr_written", read_data, 5'h15);

    // wr_en=0 leaves memory unchanged
    wr_addr = 4'd2; wr_data = 5'h1B; read_addr = 4'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("no_write_%0d", i), read_data, 5'h04);
    end

    // Write 00 to address 15, then async reset mid-cycle restores the program
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 5'h00;
    step();
    wr_en = 1'b0; read_addr = 4'd15;
    step();
    check("addr15_written", read_data, 5'h00);
    #2 rst = 1'b1;
    #1 check("reset_async_midcycle", read_data, 5'h00);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 5'h1B; read_addr = 4'd3;
    step();
    check("reset_hold_with_clk", read_data, 5'h00);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;

    read_addr = 4'd15;
    step();
    check("post_reset_addr15", read_data, 5'h1F);
    read_addr = 4'd5;
    step();
    check("post_reset_addr5", read_data, 5'h03);
    read_addr = 4'd6;
    step();
    check("post_reset_addr6", read_data, 5'h05);
    read_addr = 4'd3;
    step();
    check("write_ignored_in_reset", read_data, 5'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
